dbg_uart_host: RTL and testbench

DBG_UART_HOST -- requirements
Module: dbg_uart_host

---
 rtl/dbg_uart_host.sv | 194 +++++++++++++++++++
 tb/tb_dbg_uart_host.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_uart_host.sv
// Debug UART host: sends one 8N1 command byte to a target debug port and, for
// register reads, collects DW/8 response bytes (LSB first) with timeout/framing abort.
module dbg_uart_host #(
  parameter int CLK_DIV     = 868,
  parameter int DW          = 32,
  parameter int RSP_TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [4:0]    cmd_idx,
  output logic          uart_tx,
  input  logic          uart_rx,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RSP_TIMEOUT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, TX, RX_WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      bit_reg, bit_next;
  logic [8:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            rd_reg, rd_next;
  logic            busy_reg, busy_next;
  logic [TW-1:0]   to_reg, to_next;
  logic [BW-1:0]   byte_reg, byte_next;
  logic [7:0]      rx_byte_reg, rx_byte_next;
  logic [DW-1:0]   shadow_reg, shadow_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            err_reg, err_next;
  logic            rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic [7:0]      cmd_byte;
  logic [CW-1:0]   rx_tgt;
  logic [DW-1:0]   merged;
  logic            rx_fall;

  // Shadow with the just-completed byte dropped into its lane.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged[8*gi +: 8] = (byte_reg == BW'(gi)) ? rx_byte_reg : shadow_reg[8*gi +: 8];
  end

  assign rx_fall   = rx_prev_reg & ~rx_s2_reg;
  assign rx_tgt    = (bit_reg == 4'd0) ? HALF_LAST : BIT_LAST;
  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign rsp_err   = err_reg;
  assign uart_tx   = tx_reg;
  assign rsp_data  = data_reg;

  always_comb begin
    cmd_byte = 8'h00;
    case (cmd_op)
      2'd0: cmd_byte = 8'h01;
      2'd1: cmd_byte = 8'h02;
      2'd2: cmd_byte = 8'h03;
      default: cmd_byte = {3'b100, cmd_idx};
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    rd_next      = rd_reg;
    busy_next    = busy_reg;
    to_next      = to_reg;
    byte_next    = byte_reg;
    rx_byte_next = rx_byte_reg;
    shadow_next  = shadow_reg;
    data_next    = data_reg;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: if (cmd_valid) begin
        state_next = TX;
        shift_next = {1'b1, cmd_byte};
        tx_next    = 1'b0;
        cnt_next   = '0;
        bit_next   = 4'd0;
        rd_next    = (cmd_op == 2'd3);
      end
      TX: if (cnt_reg == BIT_LAST) begin
        cnt_next = '0;
        if (bit_reg == 4'd9) begin
          tx_next    = 1'b1;
          state_next = rd_reg ? RX_WAIT : DONE;
          to_next    = '0;
          busy_next  = 1'b0;
          byte_next  = '0;
        end else begin
          // Shift register refills with ones so the stop bit falls out last.
          tx_next    = shift_reg[0];
          shift_next = {1'b1, shift_reg[8:1]};
          bit_next   = bit_reg + 4'd1;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      RX_WAIT: if (!busy_reg) begin
        if (to_reg == TO_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          to_next = to_reg + 1'b1;
          if (rx_fall) begin
            busy_next = 1'b1;
            cnt_next  = '0;
            bit_next  = 4'd0;
          end
        end
      end else if (cnt_reg == rx_tgt) begin
        cnt_next = '0;
        if (bit_reg == 4'd0) begin
          if (rx_s2_reg) busy_next = 1'b0;
          else           bit_next  = 4'd1;
        end else if (bit_reg != 4'd9) begin
          rx_byte_next = {rx_s2_reg, rx_byte_reg[7:1]};
          bit_next     = bit_reg + 4'd1;
        end else begin
          busy_next = 1'b0;
          if (!rx_s2_reg) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            to_next     = '0;
            shadow_next = merged;
            if (byte_reg == BYTE_LAST) begin
              data_next  = merged;
              state_next = DONE;
            end else begin
              byte_next = byte_reg + 1'b1;
            end
          end
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '1;
      tx_reg      <= 1'b1;
      rd_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      to_reg      <= '0;
      byte_reg    <= '0;
      rx_byte_reg <= '0;
      shadow_reg  <= '0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      rd_reg      <= rd_next;
      busy_reg    <= busy_next;
      to_reg      <= to_next;
      byte_reg    <= byte_next;
      rx_byte_reg <= rx_byte_next;
      shadow_reg  <= shadow_next;
      data_reg    <= data_next;
      err_reg     <= err_next;
      rx_s1_reg   <= uart_rx;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end
endmodule

// File: tb/tb_dbg_uart_host.sv
// Bench for dbg_uart_host: transaction-level model of frames, response timing and
// held read data, checked every cycle plus directed step/read/timeout/framing/glitch/reset cases.
module tb_dbg_uart_host;
  localparam int D  = 4;
  localparam int DW = 32;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [4:0]    cmd_idx;
  logic          uart_tx;
  logic          uart_rx;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  dbg_uart_host #(.CLK_DIV(D), .DW(DW), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .uart_tx(uart_tx), .uart_rx(uart_rx),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  bit tx_active = 0;
  bit tx_read = 0;
  bit rd_pending = 0;
  bit skip_cmp = 1;
  logic [7:0]    tx_byte = 8'h00;
  logic [DW-1:0] exp_data = '0;
  logic [9:0]    last_cap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cmd_byte_m(input logic [1:0] op, input logic [4:0] idx);
    if (op == 2'd3) return 8'h80 + {3'b000, idx};
    return {6'd0, op} + 8'd1;
  endfunction

  // Line level c cycles after acceptance: 10 bits of D cycles, start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[c / D];
  endfunction

  always @(negedge clk) begin : cmp
    int c;
    if (rst_n && !skip_cmp) begin
      if (rsp_valid) valid_cnt++;
      if (rsp_err) err_cnt++;
      chk(!(rsp_valid && rsp_err), "valid_err_exclusive", {30'd0, rsp_valid, rsp_err}, 32'd0);
      if (!rd_pending) chk(rsp_data == exp_data, "rsp_data_held", rsp_data, exp_data);
      if (tx_active) begin
        c = cyc - acc_cyc;
        if (c < 10 * D) begin
          chk(uart_tx == frame_bit(tx_byte, c), "uart_tx_bit", {31'd0, uart_tx}, {31'd0, frame_bit(tx_byte, c)});
          chk(cmd_ready == 1'b0, "ready_low_in_tx", {31'd0, cmd_ready}, 32'd0);
          chk(!rsp_valid && !rsp_err, "no_pulse_in_tx", {30'd0, rsp_valid, rsp_err}, 32'd0);
        end else begin
          chk(uart_tx == 1'b1, "tx_after_stop", {31'd0, uart_tx}, 32'd1);
          chk(rsp_valid == !tx_read, "done_pulse_timing", {31'd0, rsp_valid}, {31'd0, !tx_read});
          tx_active = 0;
        end
      end else begin
        chk(uart_tx == 1'b1, "tx_idle_high", {31'd0, uart_tx}, 32'd1);
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] idx);
    @(negedge clk);
    chk(cmd_ready == 1'b1, "ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op;
    cmd_idx = idx;
    cmd_valid = 1'b1;
    tx_byte = cmd_byte_m(op, idx);
    tx_read = (op == 2'd3);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    tx_active = 1;
  endtask

  // Runs through the command frame, sampling mid-bit and toggling uart_rx as noise; ends at c=10*D.
  task automatic tx_wait(output logic [9:0] cap);
    cap = '0;
    for (int n = 0; n <= 10 * D; n++) begin
      @(negedge clk);
      if (n < 10 * D && (n % D) == D / 2) cap[n / D] = uart_tx;
      uart_rx = (n < 10 * D - 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (D) @(negedge clk);
    end
  endtask

  task automatic do_ctrl(input logic [1:0] op, output logic [9:0] cap);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_cmd(op, 5'($urandom));
    tx_wait(cap);
    @(negedge clk);
    chk(cmd_ready == 1'b1, "ready_after_ctrl", {31'd0, cmd_ready}, 32'd1);
    chk(valid_cnt - v0 == 1, "ctrl_valid_count", valid_cnt - v0, 32'd1);
    chk(err_cnt == e0, "ctrl_err_count", err_cnt - e0, 32'd0);
    $display("ctrl op=%0d frame=%b", op, cap);
  endtask

  task automatic do_read(input logic [4:0] idx, input logic [31:0] val, input int bad,
                         input bit glitch, input bit silent);
    int v0, e0, n;
    logic [9:0] cap;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_cmd(2'd3, idx);
    tx_wait(cap);
    last_cap = cap;
    if (silent) begin
      n = 0;
      while (!rsp_err && n < TO + 60) begin
        @(negedge clk);
        n++;
      end
      chk(rsp_err == 1'b1, "timeout_pulse", {31'd0, rsp_err}, 32'd1);
      chk(n == TO, "timeout_latency", n, TO);
      @(negedge clk);
      chk(err_cnt - e0 == 1, "timeout_err_count", err_cnt - e0, 32'd1);
      chk(valid_cnt == v0, "timeout_valid_count", valid_cnt - v0, 32'd0);
      $display("read idx=%0d timeout after %0d cycles data=%h", idx, n, rsp_data);
    end else begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      if (glitch) begin
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
        send_frame(val[8*k +: 8], (k != bad));
        if (k == bad) break;
        if (k < 3) begin
          uart_rx = 1'b1;
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
      uart_rx = 1'b1;
      rd_pending = 1;
      n = 0;
      while (!rsp_valid && !rsp_err && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (bad < 0) begin
        chk(rsp_valid == 1'b1, "read_done_pulse", {31'd0, rsp_valid}, 32'd1);
        exp_data = val;
      end else begin
        chk(rsp_err == 1'b1, "framing_err_pulse", {31'd0, rsp_err}, 32'd1);
      end
      rd_pending = 0;
      @(negedge clk);
      chk(valid_cnt - v0 == ((bad < 0) ? 1 : 0), "read_valid_count", valid_cnt - v0, (bad < 0) ? 1 : 0);
      chk(err_cnt - e0 == ((bad < 0) ? 0 : 1), "read_err_count", err_cnt - e0, (bad < 0) ? 0 : 1);
      $display("read idx=%0d sent=%h bad=%0d glitch=%0d data=%h", idx, val, bad, glitch, rsp_data);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    int v0, e0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_idx = 5'd0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(uart_tx == 1'b1, "reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk(cmd_ready == 1'b1, "reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk(rsp_valid == 1'b0, "reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk(rsp_err == 1'b0, "reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk(rsp_data == 32'd0, "reset_rsp_data", rsp_data, 32'd0);
    skip_cmp = 0;

    do_ctrl(2'd0, cap);
    chk(cap == 10'b1000000010, "step_frame_0x01", {22'd0, cap}, {22'd0, 10'b1000000010});

    do_read(5'd5, 32'h12345678, -1, 0, 0);
    chk(last_cap == 10'b1100001010, "read_frame_0x85", {22'd0, last_cap}, {22'd0, 10'b1100001010});
    chk(rsp_data == 32'h12345678, "read_value", rsp_data, 32'h12345678);

    do_read(5'd9, 32'h0, -1, 0, 1);
    chk(rsp_data == 32'h12345678, "timeout_keeps_data", rsp_data, 32'h12345678);

    do_read(5'd1, 32'hCAFEF00D, 1, 0, 0);
    chk(rsp_data == 32'h12345678, "framing_keeps_data", rsp_data, 32'h12345678);
    do_read(5'd2, 32'hDEADBEEF, -1, 0, 0);
    chk(rsp_data == 32'hDEADBEEF, "read_after_framing", rsp_data, 32'hDEADBEEF);

    do_read(5'd31, $urandom, -1, 1, 0);

    for (int i = 0; i < 12; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3) do_read(5'($urandom), $urandom, -1, 0, 0);
      else begin
        do_ctrl(op, cap);
        chk(cap == {1'b1, cmd_byte_m(op, 5'd0), 1'b0}, "ctrl_frame", {22'd0, cap}, {22'd0, 1'b1, cmd_byte_m(op, 5'd0), 1'b0});
      end
    end

    // Reset while bit 4 of a command frame is on the line.
    send_cmd(2'd1, 5'd0);
    repeat (4 * D + 1) @(negedge clk);
    skip_cmp = 1;
    rst_n = 1'b0;
    tx_active = 0;
    exp_data = '0;
    @(negedge clk);
    chk(uart_tx == 1'b1, "rst_midtx_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk(rsp_valid == 1'b0, "rst_midtx_valid", {31'd0, rsp_valid}, 32'd0);
    chk(rsp_err == 1'b0, "rst_midtx_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(cmd_ready == 1'b1, "rst_midtx_ready", {31'd0, cmd_ready}, 32'd1);
    chk(uart_tx == 1'b1, "rst_midtx_tx_idle", {31'd0, uart_tx}, 32'd1);
    skip_cmp = 0;
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (50) @(negedge clk);
    chk(valid_cnt == v0 && err_cnt == e0, "rst_midtx_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
    $display("reset mid-tx: tx=%b ready=%b data=%h", uart_tx, cmd_ready, rsp_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
